// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between the execute
// stage (req0) and address generation (req1); MUL holds the ALU for MUL_LAT cycles.
module alu_arbiter #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  input  logic [3:0]  req1_op,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result
);

  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic        rr_last_q;
  logic [3:0]  cnt_q;
  logic        owner_q;
  logic [31:0] src1_q, src2_q;
  logic [3:0]  op_q;
  logic        rsp_valid_q, rsp_id_q;
  logic [31:0] rsp_result_q;

  logic        gnt0, gnt1, hs;
  logic [31:0] src1_d, src2_d;
  logic [3:0]  op_d;

  // rr_last_q names the requester granted most recently; a tie goes to the other one.
  always_comb begin
    gnt0   = req0_valid && (!req1_valid || rr_last_q);
    gnt1   = req1_valid && !gnt0;
    hs     = (state_q == IDLE) && !reset && (gnt0 || gnt1);
    src1_d = gnt1 ? req1_src1 : req0_src1;
    src2_d = gnt1 ? req1_src2 : req0_src2;
    op_d   = gnt1 ? req1_op   : req0_op;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE && !reset) begin
      req0_ready = gnt0;
      req1_ready = gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q    <= 1'b1;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      src1_q       <= '0;
      src2_q       <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (hs) begin
        src1_q    <= src1_d;
        src2_q    <= src2_d;
        op_q      <= op_d;
        owner_q   <= gnt1;
        rr_last_q <= gnt1;
        cnt_q     <= (op_d == OP_MUL) ? MUL_CNT : 4'd0;
      end else if (state_q == BUSY) begin
        if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          rsp_valid_q  <= 1'b1;
          rsp_id_q     <= owner_q;
          rsp_result_q <= alu_result;
        end
      end
    end
  end

  assign alu_src1   = src1_q;
  assign alu_src2   = src2_q;
  assign alu_op     = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule
